// File: rtl/game_event_generator_pkg.sv
// Shared definitions for the game event generator and the game state controller.
//   - game_state_e : controller state encoding (01 is treated as TITLE)
//   - seq_state_e  : restart sequencer states
//   - default timing/geometry constants and counter width helper
package game_event_generator_pkg;

  typedef enum logic [1:0] {
    GS_TITLE     = 2'b00,
    GS_TITLE_ALT = 2'b01,
    GS_PLAYING   = 2'b10,
    GS_GAME_OVER = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE     = 2'b00,
    SEQ_WAIT_MIN = 2'b01,
    SEQ_ARMED    = 2'b10,
    SEQ_FIRE     = 2'b11
  } seq_state_e;

  localparam int unsigned DEF_COORD_W           = 10;
  localparam int unsigned DEF_NUM_GHOSTS        = 4;
  localparam int unsigned DEF_HIT_DIST          = 12;
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int unsigned DEF_GO_MIN_CYCLES     = 100_000_000;
  localparam int unsigned DEF_GO_TIMEOUT_CYCLES = 500_000_000;

  // Cycle counters get one spare bit above what the largest count needs.
  function automatic int unsigned cnt_width(input int unsigned max_cycles);
    return $clog2(max_cycles) + 1;
  endfunction

endpackage

// File: rtl/game_event_generator_btn_debounce.sv
// Button synchroniser, debouncer and rising-edge pulse generator.
//   clk_i     : system clock
//   reset     : asynchronous active-high reset
//   btn_raw_i : raw pushbutton, asynchronous to clk_i
//   pulse_o   : one-cycle pulse the cycle after the debounced level rises
module btn_debounce
  import game_event_generator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic reset,
  input  logic btn_raw_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      pulse_q     <= level_q & ~level_dly_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/game_event_generator.sv
// Event generator feeding the game state controller: debounced button pulse,
// Pac-Man/ghost collision level and the game-over restart request.
//   clk_i        : system clock
//   reset        : asynchronous active-high reset
//   btn_raw_i    : raw centre pushbutton
//   game_state_i : controller state read back (TITLE/PLAYING/GAME_OVER)
//   pac_x_i/y_i  : Pac-Man position
//   ghost_x_i/y_i: packed ghost positions, ghost 0 in the LSBs
//   btn_pulse_o  : one-cycle debounced press pulse
//   collision_o  : registered overlap level, only during PLAYING
//   restart_o    : one-cycle restart request out of GAME_OVER
module game_event_generator
  import game_event_generator_pkg::*;
#(
  parameter int unsigned COORD_W           = DEF_COORD_W,
  parameter int unsigned NUM_GHOSTS        = DEF_NUM_GHOSTS,
  parameter int unsigned HIT_DIST          = DEF_HIT_DIST,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned GO_MIN_CYCLES     = DEF_GO_MIN_CYCLES,
  parameter int unsigned GO_TIMEOUT_CYCLES = DEF_GO_TIMEOUT_CYCLES
) (
  input  logic                          clk_i,
  input  logic                          reset,
  input  logic                          btn_raw_i,
  input  logic [1:0]                    game_state_i,
  input  logic [COORD_W-1:0]            pac_x_i,
  input  logic [COORD_W-1:0]            pac_y_i,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x_i,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y_i,
  output logic                          btn_pulse_o,
  output logic                          collision_o,
  output logic                          restart_o
);

  localparam int unsigned SEQ_MAX   = (GO_TIMEOUT_CYCLES > GO_MIN_CYCLES) ?
                                      GO_TIMEOUT_CYCLES : GO_MIN_CYCLES;
  localparam int unsigned SEQ_CNT_W = cnt_width(SEQ_MAX);
  localparam logic [SEQ_CNT_W-1:0] MIN_LAST = SEQ_CNT_W'(GO_MIN_CYCLES - 1);
  localparam logic [SEQ_CNT_W-1:0] TO_LAST  = SEQ_CNT_W'(GO_TIMEOUT_CYCLES - 1);
  // One extra bit so any HIT_DIST up to the full coordinate range is representable.
  localparam logic [COORD_W:0]     HIT_LIM  = (COORD_W+1)'(HIT_DIST);

  // ---------------------------------------------------------------- button
  logic btn_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i    (clk_i),
    .reset    (reset),
    .btn_raw_i(btn_raw_i),
    .pulse_o  (btn_pulse)
  );

  assign btn_pulse_o = btn_pulse;

  // ------------------------------------------------------------- collision
  logic [NUM_GHOSTS-1:0] hit_c;
  logic                  collision_q;

  // Absolute differences taken by ordering the operands, so nothing wraps.
  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
    logic [COORD_W-1:0] gx, gy, dx, dy;
    assign gx       = ghost_x_i[g*COORD_W +: COORD_W];
    assign gy       = ghost_y_i[g*COORD_W +: COORD_W];
    assign dx       = (gx >= pac_x_i) ? (gx - pac_x_i) : (pac_x_i - gx);
    assign dy       = (gy >= pac_y_i) ? (gy - pac_y_i) : (pac_y_i - gy);
    assign hit_c[g] = ({1'b0, dx} <= HIT_LIM) && ({1'b0, dy} <= HIT_LIM);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= (game_state_i == GS_PLAYING) && (|hit_c);
    end
  end

  assign collision_o = collision_q;

  // ------------------------------------------------------ restart sequencer
  seq_state_e           state_q, state_d;
  logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;
  logic                 fired_q, fired_d;
  logic                 restart_q, restart_d;
  logic                 in_go_c;

  assign in_go_c = (game_state_i == GS_GAME_OVER);

  // fired_q blocks a second sequence until the controller leaves GAME_OVER.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fired_d = in_go_c ? (fired_q | (state_q == SEQ_FIRE)) : 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (in_go_c && !fired_q) begin
          cnt_d   = '0;
          state_d = SEQ_WAIT_MIN;
        end
      end
      SEQ_WAIT_MIN: begin
        if (!in_go_c) begin
          state_d = SEQ_IDLE;
        end else begin
          cnt_d = cnt_q + SEQ_CNT_W'(1);
          if (cnt_q == MIN_LAST) state_d = SEQ_ARMED;
        end
      end
      SEQ_ARMED: begin
        if (!in_go_c) begin
          state_d = SEQ_IDLE;
        end else begin
          cnt_d = cnt_q + SEQ_CNT_W'(1);
          if (btn_pulse || (cnt_q == TO_LAST)) state_d = SEQ_FIRE;
        end
      end
      SEQ_FIRE: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
    restart_d = (state_d == SEQ_FIRE);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q   <= SEQ_IDLE;
      cnt_q     <= '0;
      fired_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fired_q   <= fired_d;
      restart_q <= restart_d;
    end
  end

  assign restart_o = restart_q;

endmodule

// File: doc/game_event_generator.md
Name: game_event_generator

Overview:
- Produces the event inputs that the game state controller consumes: `btn_pulse_o` drives btnC_i, `collision_o` drives collision, `restart_o` drives k.
- Reads the current game_state back from the controller and gates its outputs by state.
- Contains three functions: the button synchroniser/debouncer, the Pac-Man/ghost overlap detector, and the game-over restart sequencer.
- Sits between board I/O plus sprite position logic and the state controller, in the clk_i domain.

Parameters:
- COORD_W, 10, bit width of each pixel coordinate.
- NUM_GHOSTS, 4, number of ghost positions checked.
- HIT_DIST, 12, per-axis pixel distance at or below which a ghost overlaps Pac-Man.
- DEBOUNCE_CYCLES, 1_000_000, cycles the synchronised button must be stable before its level is accepted (10 ms at 100 MHz).
- GO_MIN_CYCLES, 100_000_000, minimum GAME_OVER dwell before a button press may restart.
- GO_TIMEOUT_CYCLES, 500_000_000, GAME_OVER dwell after which restart fires with no press.

Ports:
- clk_i  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_raw_i  in  1  raw centre pushbutton, asynchronous to clk_i.
- game_state_i  in  2  controller state: 00 TITLE, 10 PLAYING, 11 GAME_OVER, 01 treated as TITLE.
- pac_x_i  in  COORD_W  Pac-Man x position.
- pac_y_i  in  COORD_W  Pac-Man y position.
- ghost_x_i  in  NUM_GHOSTS*COORD_W  packed ghost x positions; ghost 0 in the LSBs.
- ghost_y_i  in  NUM_GHOSTS*COORD_W  packed ghost y positions; ghost 0 in the LSBs.
- btn_pulse_o  out  1  one-cycle pulse on each debounced rising edge of the button.
- collision_o  out  1  registered level, high while any ghost overlaps Pac-Man during PLAYING.
- restart_o  out  1  one-cycle restart request during GAME_OVER.

Behaviour:
- Reset is asynchronous and active-high, clock is clk_i.
  - All flops clear on reset.
  - btn_pulse_o=0, collision_o=0, restart_o=0.
  - Debounced level=0, sequencer in IDLE.
- Button path:
  - Two-flop synchroniser on btn_raw_i.
  - Debounce counter resets whenever the synchronised value equals the debounced level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level toggles and the counter clears.
  - btn_pulse_o=1 for exactly the one cycle after the debounced level goes 0->1. Falling edges produce nothing.
  - Holding the button produces exactly one pulse.
  - Total latency from a stable raw edge to the pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Collision path:
  - For each ghost, compute |dx| and |dy| as unsigned absolute differences at COORD_W bits, with no wrap.
  - A ghost hits when |dx| <= HIT_DIST and |dy| <= HIT_DIST.
  - Hits are OR-reduced across all ghosts.
  - collision_o is registered with one-cycle latency, and is forced to 0 in the cycle after game_state_i != PLAYING.
  - Equal coordinates count as a hit. A distance of HIT_DIST+1 on either axis does not.
- Restart sequencer, states IDLE, WAIT_MIN, ARMED, FIRE, with one cycle counter:
  - IDLE: when game_state_i == GAME_OVER, clear the counter and go to WAIT_MIN.
  - WAIT_MIN: counter increments. Button pulses are ignored. When counter == GO_MIN_CYCLES-1, go to ARMED; the counter keeps counting.
  - ARMED: counter increments. Go to FIRE on btn_pulse_o=1 or on counter == GO_TIMEOUT_CYCLES-1.
  - FIRE: restart_o=1 for this one cycle, then go to IDLE.
  - IDLE stays in IDLE while the state is still GAME_OVER after FIRE; re-entry requires leaving GAME_OVER first. Track this with an armed-entry flag that is set in FIRE and cleared when the state != GAME_OVER.
  - If game_state_i leaves GAME_OVER while in WAIT_MIN or ARMED, go to IDLE next cycle with no restart.
  - restart_o follows a button pulse by one cycle, so the same press never reaches the controller as btnC_i in TITLE.
- Simultaneous button pulse and timeout in ARMED: a single FIRE.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs 0.
- Counters are sized with $clog2 of the largest cycle parameter, plus one bit. No counter wraps.

Decomposition:
- Shared package/include holds:
  - state encodings TITLE=2'b00, PLAYING=2'b10, GAME_OVER=2'b11, reused by the controller;
  - sequencer encodings IDLE/WAIT_MIN/ARMED/FIRE;
  - default timing constants.
- One sub-module, `btn_debounce`: synchroniser, debounce counter and rising-edge pulse. Parameterised by DEBOUNCE_CYCLES.
- Collision compare stays inline as a generate loop over NUM_GHOSTS.

Test Plan (bench overrides DEBOUNCE_CYCLES=8, GO_MIN_CYCLES=20, GO_TIMEOUT_CYCLES=50):
- Bounce: raw toggles every 3 cycles for 30 cycles, then holds 1 for 20 cycles -> exactly one btn_pulse_o, 11 cycles after the hold starts, and none on release.
- Collision edge: PLAYING, pac=(100,100), ghost2=(112,88) -> collision_o=1 one cycle later. Move ghost2 to (113,100) -> 0 one cycle later. Switch to TITLE with overlap kept -> collision_o=0.
- Early press: enter GAME_OVER, debounced press at cycle 5 -> no restart_o. Press at cycle 25 -> restart_o=1 for exactly the one cycle after btn_pulse_o.
- Timeout: enter GAME_OVER, no press -> restart_o=1 once, at cycle 50 after entry. Hold GAME_OVER 30 more cycles -> no second pulse.
- Exit mid-wait: GAME_OVER for 30 cycles, then TITLE -> restart_o stays 0. Re-enter GAME_OVER -> the timeout restarts from 0.
- Async reset: assert during ARMED with collision_o=1 -> all outputs 0 with no clock edge, sequencer IDLE after release.
